arm_mem_access_unit: RTL
========================

# arm_mem_access_unit

Parametrised memory stage between the EX/MEM and MEM/WB pipeline registers. It drives a request/acknowledge data-memory port that may take several cycles, and stalls the pipeline while the access is outstanding. Supported accesses are byte, halfword and word loads (signed or unsigned) and byte, halfword and word stores, on a 32- or 64-bit memory bus. It detects misaligned accesses and timeouts, and registers the load result and writeback controls into MEM/WB.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width.
- `BUS_W`, 32, memory bus width; legal values are 32 and 64. `OFF_W = log2(BUS_W/8)`.
- `TIMEOUT_CYC`, 0, maximum WAIT cycles before abort; 0 disables the timeout.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_b` in 1: reset, asynchronous, active-low.
- `ex_valid` in 1: EX/MEM holds a valid instruction.
- `ex_op` in 4: `mem_op_t` (`NONE, LDB, LDSB, LDH, LDSH, LDW, STB, STH, STW`).
- `ex_addr` in `ADDR_W`: effective byte address.
- `ex_st_data` in 32: store data, right-aligned.
- `ex_rd_data` in 32: ALU result, passed through.
- `ex_rd_we` in 1, `ex_rd_data_sel` in 1, `ex_des_reg_num` in 4: writeback controls.
- `mem_req` out 1: access request.
- `mem_we` out 1: 1 = store.
- `mem_addr` out `ADDR_W-OFF_W`: bus-word address.
- `mem_be` out `BUS_W/8`: byte enables.
- `mem_wdata` out `BUS_W`: store data.
- `mem_rdata` in `BUS_W`: read data, valid while `mem_ack` is high.
- `mem_ack` in 1: access complete.
- `stall` out 1: freeze PC, IF/ID, ID/EX and EX/MEM.
- `wb_valid`, `wb_rd_we`, `wb_rd_data_sel` out 1 each; `wb_des_reg_num` out 4.
- `wb_load_data` out 32, `wb_rd_data` out 32.
- `wb_fault` out 1: misalignment or timeout for the instruction now in WB.

## Operation
- The FSM has two states, IDLE and WAIT. An access is defined as `ex_valid && ex_op != NONE && aligned`.
- Alignment rules: halfword requires `addr[0]==0`; word requires `addr[1:0]==0`. Bytes are always aligned. With 64-bit `BUS_W`, halfword and word accesses never straddle the bus word because of these rules.

IDLE:
- On an access, drive `mem_req=1` combinationally.
- If `mem_ack` arrives the same cycle, complete the access and stay in IDLE.
- Otherwise go to WAIT.

WAIT:
- Hold `mem_req`, `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` stable. Upstream holds `ex_*` stable while `stall` is high.
- On `mem_ack`, complete the access and return to IDLE.
- If `TIMEOUT_CYC>0` and the wait counter reaches `TIMEOUT_CYC` without an ack, abort: deassert `mem_req`, return to IDLE, and complete with fault.
- An ack arriving in the same cycle as the timeout wins; no fault is raised.

Stall and completion:
- `stall = access && !mem_ack && !timeout_hit`, combinational.
- A non-memory valid instruction, or `NONE`, completes in one cycle with no request.
- Misaligned access: no `mem_req`. The instruction completes immediately with `wb_fault=1` and `wb_rd_we` forced to 0.
- Timeout completion likewise forces `wb_rd_we=0` and sets `wb_fault=1`.

Data paths:
- Load extraction: `lane = addr[OFF_W-1:0]`; shift `mem_rdata` right by `lane*8`, then take 8, 16 or 32 bits.
- `LDSB` and `LDSH` sign-extend to 32 bits; `LDB` and `LDH` zero-extend.
- Stores: replicate the byte or halfword across the bus; `mem_wdata` is `ex_st_data` replicated. `mem_be` is the size mask (`1`, `3` or `F` hex) shifted left by `lane`.
- `mem_we=1` only for ST ops. `mem_be=0` whenever `mem_req=0`.
- An ack while `mem_req=0` is ignored.

## Timing
- Reset: state IDLE, wait counter 0, and all `wb_*` outputs equal to 0. `mem_req`, `stall` and `mem_be` are 0 while `rst_b=0`.
- Zero-wait access: the result appears on `wb_*` at the clock edge after `ex_valid`, which is a latency of 1.
- N-wait access: `stall` is high for N cycles. `wb_*` updates at the edge after the ack cycle.
- Every cycle with `stall=1` loads a bubble into MEM/WB: `wb_valid=0`, `wb_rd_we=0`, `wb_fault=0`.
- On a completing edge, `wb_valid` equals `ex_valid`, and the `wb_*` controls copy the `ex_*` controls (subject to the fault override above).
- Reset asserted mid-WAIT: drop to IDLE asynchronously with `mem_req=0` immediately. Any ack arriving afterwards is ignored.
- Back-to-back accesses: a new access may issue in the cycle immediately after a completion; there is no turnaround cycle.

## Structure
- Package `arm_mem_pkg` holds `mem_op_t`, the `mem_state_t` enum (`IDLE`, `WAIT`), size-mask constants, and helper functions `op_is_load`, `op_is_store`, `op_size`.
- Sub-module `arm_mem_lane_align` is combinational and parametrised by `BUS_W`. It computes `mem_be`, `mem_wdata`, the extracted and extended load data, and the misalign flag.
- The top level holds the FSM, the wait counter and the MEM/WB registers.

## Test plan
- **Zero-wait byte load** (`BUS_W=32`): `LDSB` at addr `0x1003`, `mem_rdata=0x80FF1234`, ack the same cycle → `mem_addr=0x400`, `mem_be=0x8`, no stall, next cycle `wb_load_data=0xFFFFFF80`, `wb_valid=1`.
- **Halfword store on a 64-bit bus**: `STH` at `0x2006`, data `0xABCD`, ack after 3 cycles → `mem_be=0xC0`, `mem_wdata=0xABCD` replicated ×4, `stall` high for exactly 3 cycles, 3 bubbles with `wb_valid=0`, then `wb_valid=1`.
- **Misaligned load**: `LDW` at `0x1002` → `mem_req` never asserted, next cycle `wb_fault=1`, `wb_rd_we=0`.
- **Timeout**: `TIMEOUT_CYC=4`, `LDW`, ack never arrives → `stall` high for 4 cycles, `mem_req` drops, then `wb_fault=1`. A second run with ack on the 4th wait cycle gives no fault.
- **Reset mid-WAIT**: `rst_b=0` during WAIT → `mem_req=0`, `stall=0` and `wb_*` cleared immediately. A late ack after release is ignored.
- **Back-to-back**: `LDW` then `STW`, each acked the same cycle → two consecutive requests with no bubble, and the correct `wb_*` on each following cycle.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared types and helpers for the memory stage: operation and state encodings,
// access-size masks, and small op-decoding functions.
package arm_mem_pkg;

    typedef enum logic [3:0] {
        NONE = 4'd0,
        LDB  = 4'd1,
        LDSB = 4'd2,
        LDH  = 4'd3,
        LDSH = 4'd4,
        LDW  = 4'd5,
        STB  = 4'd6,
        STH  = 4'd7,
        STW  = 4'd8
    } mem_op_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_B    = 2'd0,
        SZ_H    = 2'd1,
        SZ_W    = 2'd2,
        SZ_NONE = 2'd3
    } mem_size_t;

    localparam logic [3:0] SZ_MASK_B = 4'h1;
    localparam logic [3:0] SZ_MASK_H = 4'h3;
    localparam logic [3:0] SZ_MASK_W = 4'hF;

    function automatic logic op_is_load(input mem_op_t op);
        return (op inside {LDB, LDSB, LDH, LDSH, LDW});
    endfunction

    function automatic logic op_is_store(input mem_op_t op);
        return (op inside {STB, STH, STW});
    endfunction

    function automatic logic op_is_signed(input mem_op_t op);
        return (op inside {LDSB, LDSH});
    endfunction

    function automatic mem_size_t op_size(input mem_op_t op);
        mem_size_t sz;
        case (op)
            LDB, LDSB, STB: sz = SZ_B;
            LDH, LDSH, STH: sz = SZ_H;
            LDW, STW:       sz = SZ_W;
            default:        sz = SZ_NONE;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/arm_mem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data for the
// bus, load extraction with sign/zero extension, and the alignment check.
module arm_mem_lane_align
    import arm_mem_pkg::*;
#(
    parameter int BUS_W = 32
) (
    input  mem_op_t                          op,
    input  logic [$clog2(BUS_W/8)-1:0]       lane,
    input  logic [31:0]                      st_data,
    input  logic [BUS_W-1:0]                 rdata,
    output logic [BUS_W/8-1:0]               be,
    output logic [BUS_W-1:0]                 wdata,
    output logic [31:0]                      ld_data,
    output logic                             misalign
);

    localparam int BE_W  = BUS_W / 8;

    mem_size_t        w_size;
    logic             w_sext;
    logic [BUS_W-1:0] w_shifted;
    logic [BE_W-1:0]  w_mask;

    assign w_size    = op_size(op);
    assign w_sext    = op_is_signed(op);
    assign w_shifted = rdata >> {lane, 3'b000};
    assign be        = w_mask << lane;

    always_comb begin
        w_mask   = '0;
        wdata    = '0;
        ld_data  = '0;
        misalign = 1'b0;
        case (w_size)
            SZ_B: begin
                w_mask  = BE_W'(SZ_MASK_B);
                wdata   = {(BUS_W/8){st_data[7:0]}};
                ld_data = {{24{w_sext & w_shifted[7]}}, w_shifted[7:0]};
            end
            SZ_H: begin
                w_mask   = BE_W'(SZ_MASK_H);
                wdata    = {(BUS_W/16){st_data[15:0]}};
                ld_data  = {{16{w_sext & w_shifted[15]}}, w_shifted[15:0]};
                misalign = lane[0];
            end
            SZ_W: begin
                w_mask   = BE_W'(SZ_MASK_W);
                wdata    = {(BUS_W/32){st_data}};
                ld_data  = w_shifted[31:0];
                misalign = |lane[1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/arm_mem_access_unit.sv
// Memory pipeline stage: issues req/ack data-memory accesses, stalls upstream while
// an access is outstanding, flags misalign/timeout, and registers MEM/WB.
module arm_mem_access_unit
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int BUS_W       = 32,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                               clk,
    input  logic                               rst_b,
    input  logic                               ex_valid,
    input  mem_op_t                            ex_op,
    input  logic [ADDR_W-1:0]                  ex_addr,
    input  logic [31:0]                        ex_st_data,
    input  logic [31:0]                        ex_rd_data,
    input  logic                               ex_rd_we,
    input  logic                               ex_rd_data_sel,
    input  logic [3:0]                         ex_des_reg_num,
    output logic                               mem_req,
    output logic                               mem_we,
    output logic [ADDR_W-$clog2(BUS_W/8)-1:0]  mem_addr,
    output logic [BUS_W/8-1:0]                 mem_be,
    output logic [BUS_W-1:0]                   mem_wdata,
    input  logic [BUS_W-1:0]                   mem_rdata,
    input  logic                               mem_ack,
    output logic                               stall,
    output logic                               wb_valid,
    output logic                               wb_rd_we,
    output logic                               wb_rd_data_sel,
    output logic [3:0]                         wb_des_reg_num,
    output logic [31:0]                        wb_load_data,
    output logic [31:0]                        wb_rd_data,
    output logic                               wb_fault
);

    localparam int OFF_W = $clog2(BUS_W/8);
    localparam int BE_W  = BUS_W / 8;
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYC);

    mem_state_t       r_state;
    logic [CNT_W-1:0] r_wait_cnt;

    logic             r_wb_valid;
    logic             r_wb_rd_we;
    logic             r_wb_rd_data_sel;
    logic [3:0]       r_wb_des_reg_num;
    logic [31:0]      r_wb_load_data;
    logic [31:0]      r_wb_rd_data;
    logic             r_wb_fault;

    logic [BE_W-1:0]  w_be_raw;
    logic [BUS_W-1:0] w_wdata;
    logic [31:0]      w_ld_data;
    logic             w_misalign;
    logic             w_mem_op;
    logic             w_access;
    logic             w_tmo_hit;
    logic             w_abort;
    logic             w_ack_ok;
    logic             w_fault;

    arm_mem_lane_align #(
        .BUS_W (BUS_W)
    ) u_lane_align (
        .op       (ex_op),
        .lane     (ex_addr[OFF_W-1:0]),
        .st_data  (ex_st_data),
        .rdata    (mem_rdata),
        .be       (w_be_raw),
        .wdata    (w_wdata),
        .ld_data  (w_ld_data),
        .misalign (w_misalign)
    );

    // rst_b gates the request path so nothing escapes while reset is held
    assign w_mem_op  = rst_b && ex_valid && (op_is_load(ex_op) || op_is_store(ex_op));
    assign w_access  = w_mem_op && !w_misalign;
    assign w_tmo_hit = (TIMEOUT_CYC > 0) && (r_state == WAIT) && (r_wait_cnt == TMO_VAL);
    // On the timeout cycle the request is still held if ack shows up, so the ack wins
    assign w_abort   = w_access && w_tmo_hit && !mem_ack;
    assign w_ack_ok  = mem_req && mem_ack;
    assign w_fault   = (w_mem_op && w_misalign) || w_abort;

    assign mem_req   = w_access && !w_abort;
    assign mem_we    = mem_req && op_is_store(ex_op);
    assign mem_be    = mem_req ? w_be_raw : '0;
    assign mem_wdata = w_wdata;
    assign mem_addr  = ex_addr[ADDR_W-1:OFF_W];
    assign stall     = w_access && !mem_ack && !w_tmo_hit;

    // The counter holds the number of stall cycles already spent on this access
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (stall) begin
                        r_state    <= WAIT;
                        r_wait_cnt <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (!stall) begin
                        r_state    <= IDLE;
                        r_wait_cnt <= '0;
                    end else if (TIMEOUT_CYC > 0) begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wb_valid       <= 1'b0;
            r_wb_rd_we       <= 1'b0;
            r_wb_rd_data_sel <= 1'b0;
            r_wb_des_reg_num <= '0;
            r_wb_load_data   <= '0;
            r_wb_rd_data     <= '0;
            r_wb_fault       <= 1'b0;
        end else if (stall) begin
            r_wb_valid <= 1'b0;
            r_wb_rd_we <= 1'b0;
            r_wb_fault <= 1'b0;
        end else begin
            r_wb_valid       <= ex_valid;
            r_wb_rd_we       <= ex_rd_we && !w_fault;
            r_wb_rd_data_sel <= ex_rd_data_sel;
            r_wb_des_reg_num <= ex_des_reg_num;
            r_wb_load_data   <= (w_ack_ok && op_is_load(ex_op)) ? w_ld_data : 32'h0;
            r_wb_rd_data     <= ex_rd_data;
            r_wb_fault       <= w_fault;
        end
    end

    assign wb_valid       = r_wb_valid;
    assign wb_rd_we       = r_wb_rd_we;
    assign wb_rd_data_sel = r_wb_rd_data_sel;
    assign wb_des_reg_num = r_wb_des_reg_num;
    assign wb_load_data   = r_wb_load_data;
    assign wb_rd_data     = r_wb_rd_data;
    assign wb_fault       = r_wb_fault;

endmodule
